axis_crc32_mpeg2_check: RTL and testbench

// - Receive-side partner of axis_crc32_mpeg2. Consumes AXI-Stream frames of 32-bit words: payload words, then one trailing
//   CRC32/MPEG-2 word carrying tlast. Forwards payload only, with tlast moved to the last payload word.
// - Checks the frame residue and pulses a per-frame status (ok/err/runt, payload length) for the link-statistics logic.

---
 rtl/axis_crc32_mpeg2_pkg_prm.sv | 20 ++
 rtl/axis_crc32_mpeg2_check.sv | 101 ++++++++++
 tb/tb_axis_crc32_mpeg2_check.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_crc32_mpeg2_pkg_prm.sv
// Shared CRC32/MPEG-2 constants and the single-word update used by both the
// generator and the checker (MSB-first, no reflection, no final XOR).
package axis_crc32_mpeg2_pkg_prm;

  localparam logic [31:0] INIT_CRC = 32'hFFFFFFFF;
  localparam logic [31:0] POLY_CRC = 32'h04C11DB7;

  function automatic logic [31:0] crc32_mpeg2_step(
    input logic [31:0] crc,
    input logic [31:0] data,
    input logic [31:0] poly = POLY_CRC
  );
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? poly : 32'h0);
    return c;
  endfunction

endpackage

// File: rtl/axis_crc32_mpeg2_check.sv
// Receive-side CRC32/MPEG-2 checker: strips the trailing CRC word, moves tlast
// onto the last payload word and pulses a per-frame ok/runt/length status.
module axis_crc32_mpeg2_check #(
  parameter int unsigned LEN_W    = 16,
  parameter logic [31:0] INIT_CRC = axis_crc32_mpeg2_pkg_prm::INIT_CRC,
  parameter logic [31:0] POLY_CRC = axis_crc32_mpeg2_pkg_prm::POLY_CRC
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_runt,
  output logic [LEN_W-1:0] frame_len
);
  import axis_crc32_mpeg2_pkg_prm::crc32_mpeg2_step;

  logic [31:0]      r_hold;
  logic             r_hold_v;
  logic [31:0]      r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic [31:0]      r_crc;
  logic [LEN_W-1:0] r_len;
  logic             r_done, r_ok, r_runt;
  logic [LEN_W-1:0] r_flen;

  logic             w_slot_free;
  logic             w_acc;
  logic [31:0]      w_crc_nxt;
  logic [LEN_W-1:0] w_len_inc;

  assign w_slot_free = !r_m_valid || m_axis_tready;
  assign w_acc       = s_axis_tvalid && s_axis_tready;
  assign w_crc_nxt   = crc32_mpeg2_step(r_crc, s_axis_tdata, POLY_CRC);
  assign w_len_inc   = (&r_len) ? r_len : r_len + LEN_W'(1);

  // A word is only released downstream once its successor arrives, so the
  // held word can be tagged as last when the successor turns out to be the CRC.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_hold    <= '0;
      r_hold_v  <= 1'b0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_crc     <= INIT_CRC;
      r_len     <= '0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_runt    <= 1'b0;
      r_flen    <= '0;
    end else begin
      r_done <= 1'b0;
      if (m_axis_tready) r_m_valid <= 1'b0;
      if (w_acc) begin
        if (s_axis_tlast) begin
          r_crc  <= INIT_CRC;
          r_len  <= '0;
          r_done <= 1'b1;
          r_ok   <= (w_crc_nxt == 32'h0) && r_hold_v;
          r_runt <= !r_hold_v;
          r_flen <= r_hold_v ? w_len_inc : '0;
          if (r_hold_v) begin
            r_m_data  <= r_hold;
            r_m_last  <= 1'b1;
            r_m_valid <= 1'b1;
            r_hold_v  <= 1'b0;
          end
        end else begin
          r_crc    <= w_crc_nxt;
          r_hold   <= s_axis_tdata;
          r_hold_v <= 1'b1;
          if (r_hold_v) begin
            r_m_data  <= r_hold;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b1;
            r_len     <= w_len_inc;
          end
        end
      end
    end
  end

  assign s_axis_tready = !r_hold_v || w_slot_free;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign crc_done      = r_done;
  assign crc_ok        = r_ok;
  assign crc_runt      = r_runt;
  assign frame_len     = r_flen;

endmodule

// File: tb/tb_axis_crc32_mpeg2_check.sv
// Bench for axis_crc32_mpeg2_check: directed frame table, byte-table CRC model,
// scoreboard for m beats and per-frame status, ready-stall and reset cases.
module tb_axis_crc32_mpeg2_check;
  localparam int LW = 4;
  localparam int LMAX = (1 << LW) - 1;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic s_tready, m_tvalid, m_tlast, crc_done, crc_ok, crc_runt;
  logic [31:0] m_tdata;
  logic [LW-1:0] frame_len;

  axis_crc32_mpeg2_check #(.LEN_W(LW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .crc_done(crc_done), .crc_ok(crc_ok), .crc_runt(crc_runt), .frame_len(frame_len)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] d; bit last; } beat_t;
  typedef struct { bit ok; bit runt; int len; } st_t;
  typedef struct { int n; logic [2:0][31:0] w; st_t st; } vec_t;

  beat_t exp_q[$];
  st_t   st_q[$];
  int    beat_cyc[$];
  int    vecs = 0, errs = 0, cyc = 0, occ = 0, rmode = 0;
  logic [31:0] tbl [256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vecs++; errs++;
    $display("FAIL %s", nm);
  endtask

  // Reference CRC: classic byte-at-a-time table form over the payload words.
  function automatic logic [31:0] model_crc(input logic [31:0] ws[$]);
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < ws.size(); i++)
      for (int b = 3; b >= 0; b--) begin
        idx = c[31:24] ^ ws[i][8*b +: 8];
        c = (c << 8) ^ tbl[idx];
      end
    return c;
  endfunction

  function automatic st_t model_status(input logic [31:0] ws[$]);
    st_t s;
    logic [31:0] pl[$];
    int np;
    np = ws.size() - 1;
    for (int i = 0; i < np; i++) pl.push_back(ws[i]);
    s.runt = (np == 0);
    s.ok   = !s.runt && (ws[np] == model_crc(pl));
    s.len  = (np > LMAX) ? LMAX : np;
    return s;
  endfunction

  function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, input bit ok, runt, input int len);
    vec_t v;
    v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.st.ok = ok; v.st.runt = runt; v.st.len = len;
    return v;
  endfunction

  task automatic queue_frame(input logic [31:0] ws[$], input st_t st);
    beat_t b;
    for (int i = 0; i < ws.size() - 1; i++) begin
      b.d = ws[i]; b.last = (i == ws.size() - 2);
      exp_q.push_back(b);
    end
    st_q.push_back(st);
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    bit acc;
    int n;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge aclk); acc = s_tready;
      @(posedge aclk); #1; n++;
    end
    if (!acc) begin
      fail_now("accept_timeout");
      s_tvalid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] ws[$], input bit gaps);
    for (int i = 0; i < ws.size(); i++) begin
      send_word(ws[i], i == ws.size() - 1);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
      end
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && n < 400) begin
      @(posedge aclk); #1; n++;
    end
    if (exp_q.size() != 0 || st_q.size() != 0) fail_now("drain_timeout");
  endtask

  function automatic void rand_frame(input int np, input bit corrupt, output logic [31:0] ws[$]);
    logic [31:0] c;
    ws.delete();
    for (int k = 0; k < np; k++) ws.push_back($urandom);
    c = model_crc(ws);
    if (corrupt) c = c ^ (32'h1 << $urandom_range(0, 31));
    ws.push_back(c);
  endfunction

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    #1;
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  // Scoreboard: everything is sampled mid-cycle; occ counts payload words
  // accepted but not yet taken downstream (2 means hold and output are full).
  logic pstall = 1'b0;
  logic [32:0] pbeat = '0;
  beat_t mb;
  st_t ms;
  always @(negedge aclk) begin
    if (areset) pstall = 1'b0;
    else begin
      chk("s_tready", 64'(s_tready), 64'((occ == 2) ? m_tready : 1'b1));
      if (pstall) chk("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, pbeat}));
      if (m_tvalid && m_tready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("extra_m_beat");
        else begin
          mb = exp_q.pop_front();
          chk("m_beat", 64'({m_tlast, m_tdata}), 64'({mb.last, mb.d}));
        end
      end
      if (crc_done) begin
        if (st_q.size() == 0) fail_now("extra_crc_done");
        else begin
          ms = st_q.pop_front();
          chk("status", 64'({crc_ok, crc_runt, frame_len}), 64'({ms.ok, ms.runt, LW'(ms.len)}));
        end
      end
      occ += int'(s_tvalid && s_tready && !s_tlast) - int'(m_tvalid && m_tready);
      pstall = m_tvalid && !m_tready;
      pbeat  = {m_tlast, m_tdata};
    end
  end

  initial begin
    vec_t tv[4];
    logic [31:0] ws[$];
    logic [31:0] r;
    st_t st;

    for (int i = 0; i < 256; i++) begin
      r = 32'(i) << 24;
      for (int b = 0; b < 8; b++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      tbl[i] = r;
    end

    tv[0] = mk(2, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0, 1);
    tv[1] = mk(2, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1);
    tv[2] = mk(1, 32'h12345678, 32'h0,        32'h0, 1'b0, 1'b1, 0);
    tv[3] = mk(3, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 1'b0, 2);

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_sready", 64'(s_tready), 64'd1);
    chk("rst_mvalid", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
    chk("rst_status", 64'({crc_done, crc_ok, crc_runt, frame_len}), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Directed frames
    for (int t = 0; t < 4; t++) begin
      ws.delete();
      for (int i = 0; i < tv[t].n; i++) ws.push_back(tv[t].w[i]);
      queue_frame(ws, tv[t].st);
      send_frame(ws, 1'b0);
      idle();
      drain();
    end

    // Two 8-word frames back to back at full rate
    beat_cyc.delete();
    for (int f = 0; f < 2; f++) begin
      rand_frame(8, 1'b0, ws);
      queue_frame(ws, model_status(ws));
      send_frame(ws, 1'b0);
    end
    idle();
    drain();
    if (beat_cyc.size() != 16) fail_now("burst_beat_count");
    else begin
      chk("burst0_span", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);
      chk("burst1_span", 64'(beat_cyc[15] - beat_cyc[8]), 64'd7);
    end

    // Downstream held off for 20 cycles mid-frame
    rmode = 2;
    rand_frame(5, 1'b0, ws);
    queue_frame(ws, model_status(ws));
    fork send_frame(ws, 1'b0); join_none
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    chk("stall_sready", 64'(s_tready), 64'd0);
    repeat (10) @(posedge aclk);
    rmode = 0;
    wait fork;
    idle();
    drain();

    // Random frames under random backpressure, some corrupted, some runts
    rmode = 1;
    for (int f = 0; f < 30; f++) begin
      rand_frame($urandom_range(0, 6), 1'($urandom_range(0, 1)), ws);
      queue_frame(ws, model_status(ws));
      send_frame(ws, 1'b1);
    end
    idle();
    rmode = 0;
    drain();

    // Length saturation
    rand_frame(20, 1'b0, ws);
    queue_frame(ws, model_status(ws));
    send_frame(ws, 1'b0);
    idle();
    drain();

    // Reset after three payload words; the partial frame must vanish
    ws.delete();
    for (int i = 0; i < 3; i++) ws.push_back($urandom);
    mb.d = ws[0]; mb.last = 1'b0; exp_q.push_back(mb);
    mb.d = ws[1]; exp_q.push_back(mb);
    for (int i = 0; i < 3; i++) send_word(ws[i], 1'b0);
    idle();
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("mid_rst_m", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
    chk("mid_rst_status", 64'({crc_done, frame_len}), 64'd0);
    chk("mid_rst_sready", 64'(s_tready), 64'd1);
    areset = 1'b0;
    exp_q.delete();
    occ = 0;
    ws.delete();
    ws.push_back(32'hFFFFFFFF); ws.push_back(32'h00000000);
    st.ok = 1'b1; st.runt = 1'b0; st.len = 1;
    queue_frame(ws, st);
    send_frame(ws, 1'b0);
    idle();
    drain();
    repeat (3) @(posedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
